// File: rtl/axi_rd_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI-4 read master.
// Only one burst is outstanding at a time. The owner keeps the grant until
// its last R beat. The R channel has no RLAST, so the arbiter finds the last
// beat by counting beats from the accepted arlen.
module axi_rd_arbiter #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter logic [3:0]  ARCACHE = 4'b1110,
  parameter logic        ARUSER  = 1'b1,
  parameter logic [2:0]  ARPROT  = 3'b000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [3:0]        m_arcache,
  output logic              m_aruser,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_owner, last_owner_d;   // 0 = requester 0 served last, 1 = requester 1
  logic [8:0] beat_cnt, beat_cnt_d;       // 9 bits so that arlen 255 loads 256
  logic       sel_rready;

  // The AR payload and the R data go straight through. Only the handshakes are gated.
  assign m_araddr  = grant_q[1] ? s1_araddr : s0_araddr;
  assign m_arlen   = grant_q[1] ? s1_arlen  : s0_arlen;
  assign m_arcache = ARCACHE;
  assign m_aruser  = ARUSER;
  assign m_arprot  = ARPROT;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign busy      = (state != IDLE);
  assign grant     = grant_q;

  // State, owner, round-robin history and beat counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_q    <= 2'b00;
      last_owner <= 1'b1;
      beat_cnt   <= 9'd0;
    end else begin
      state      <= state_d;
      grant_q    <= grant_d;
      last_owner <= last_owner_d;
      beat_cnt   <= beat_cnt_d;
    end
  end

  // Next-state logic, arbitration decision and per-state handshake routing.
  always_comb begin
    state_d      = state;
    grant_d      = grant_q;
    last_owner_d = last_owner;
    beat_cnt_d   = beat_cnt;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    s0_arready   = 1'b0;
    s1_arready   = 1'b0;
    s0_rvalid    = 1'b0;
    s1_rvalid    = 1'b0;
    sel_rready   = grant_q[1] ? s1_rready : s0_rready;
    case (state)
      IDLE: begin
        if (s0_arvalid && s1_arvalid) begin
          // On a tie, the requester that did not own the last burst wins.
          grant_d = last_owner ? 2'b01 : 2'b10;
          state_d = ADDR;
        end else if (s0_arvalid) begin
          grant_d = 2'b01;
          state_d = ADDR;
        end else if (s1_arvalid) begin
          grant_d = 2'b10;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_arvalid  = 1'b1;
        s0_arready = grant_q[0] & m_arready;
        s1_arready = grant_q[1] & m_arready;
        if (m_arready) begin
          beat_cnt_d = {1'b0, m_arlen} + 9'd1;
          state_d    = DATA;
        end
      end
      DATA: begin
        m_rready  = sel_rready;
        s0_rvalid = grant_q[0] & m_rvalid;
        s1_rvalid = grant_q[1] & m_rvalid;
        if (m_rvalid && sel_rready) begin
          beat_cnt_d = beat_cnt - 9'd1;
          if (beat_cnt == 9'd1) begin
            state_d      = IDLE;
            last_owner_d = grant_q[1];
            grant_d      = 2'b00;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed testbench for axi_rd_arbiter. The master side is driven by hand.
// Expected values are written out directly at each step.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] s0_araddr, s1_araddr;
  logic [7:0]  s0_arlen, s1_arlen;
  logic        s0_arvalid, s1_arvalid;
  logic        s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata;
  logic        s0_rvalid, s1_rvalid;
  logic        s0_rready, s1_rready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [3:0]  m_arcache;
  logic        m_aruser;
  logic [2:0]  m_arprot;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_rready;
  logic        busy;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  axi_rd_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arvalid(s0_arvalid),
    .s0_arready(s0_arready), .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid),
    .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arvalid(s1_arvalid),
    .s1_arready(s1_arready), .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid),
    .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arcache(m_arcache),
    .m_aruser(m_aruser), .m_arprot(m_arprot), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Precondition: the DUT entered ADDR at the last edge for requester `who`.
  // The task performs the AR handshake and then delivers len+1 beats back to back.
  task automatic serve(input int who, input logic [31:0] addr, input logic [7:0] len,
                       input logic [31:0] base, input bit rearm);
    chk("addr_grant", grant, (who == 1) ? 2'b10 : 2'b01);
    chk("addr_arvalid", m_arvalid, 1'b1);
    chk("addr_araddr", m_araddr, addr);
    chk("addr_arlen", m_arlen, len);
    m_arready = 1'b1;
    #1;
    chk("arready_own", (who == 1) ? s1_arready : s0_arready, 1'b1);
    chk("arready_other", (who == 1) ? s0_arready : s1_arready, 1'b0);
    cyc();
    m_arready = 1'b0;
    if (!rearm) begin
      if (who == 1) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
    end
    if (who == 1) s1_rready = 1'b1; else s0_rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      m_rvalid = 1'b1;
      m_rdata  = base + i;
      #1;
      chk("beat_rvalid", (who == 1) ? s1_rvalid : s0_rvalid, 1'b1);
      chk("beat_rdata", (who == 1) ? s1_rdata : s0_rdata, base + i);
      chk("beat_other_rvalid", (who == 1) ? s0_rvalid : s1_rvalid, 1'b0);
      chk("beat_busy", busy, 1'b1);
      cyc();
    end
    m_rvalid = 1'b0;
    #1;
    chk("end_busy", busy, 1'b0);
    chk("end_grant", grant, 2'b00);
    chk("end_rready", m_rready, 1'b0);
  endtask

  initial begin
    int sent;
    reset_n = 1'b0;
    s0_araddr = '0; s0_arlen = '0; s0_arvalid = 1'b0; s0_rready = 1'b0;
    s1_araddr = '0; s1_arlen = '0; s1_arvalid = 1'b0; s1_rready = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
    cyc();
    cyc();
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_rready", m_rready, 1'b0);
    chk("rst_s0_arready", s0_arready, 1'b0);
    chk("rst_s1_rvalid", s1_rvalid, 1'b0);
    chk("arcache", m_arcache, 4'b1110);
    chk("aruser", m_aruser, 1'b1);
    chk("arprot", m_arprot, 3'b000);
    reset_n = 1'b1;
    cyc();

    // Single burst from requester 0.
    s0_araddr = 32'h1000; s0_arlen = 8'd3; s0_arvalid = 1'b1;
    #1;
    chk("idle_arvalid", m_arvalid, 1'b0);
    cyc();
    chk("addr_s0_arready_low", s0_arready, 1'b0);
    serve(0, 32'h1000, 8'd3, 32'hA0, 1'b0);

    // Tie after reset: requester 0 first, then 1, then requester 0 wins the next tie.
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    s0_araddr = 32'h2000; s0_arlen = 8'd0; s0_arvalid = 1'b1;
    s1_araddr = 32'h3000; s1_arlen = 8'd1; s1_arvalid = 1'b1;
    cyc();
    serve(0, 32'h2000, 8'd0, 32'hB0, 1'b0);
    cyc();
    serve(1, 32'h3000, 8'd1, 32'hC0, 1'b0);
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    cyc();
    serve(0, 32'h2000, 8'd0, 32'hB8, 1'b0);

    // Requester 1 requests continuously while requester 0 re-requests, so grants alternate.
    s1_arvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s0_araddr = 32'h2100 + k; s0_arlen = 8'd1; s0_arvalid = 1'b1;
      s1_araddr = 32'h3100 + k; s1_arlen = 8'd2;
      cyc();
      if (k % 2 == 0) serve(1, 32'h3100 + k, 8'd2, 32'hD00 + 16 * k, 1'b1);
      else            serve(0, 32'h2100 + k, 8'd1, 32'hE00 + 16 * k, 1'b0);
    end
    s1_arvalid = 1'b0;
    s0_arvalid = 1'b0;
    cyc();

    // 256-beat burst. rvalid toggles and rready is stalled for 5 cycles mid-burst.
    s0_araddr = 32'h4000; s0_arlen = 8'd255; s0_arvalid = 1'b1;
    cyc();
    m_arready = 1'b1;
    cyc();
    m_arready = 1'b0; s0_arvalid = 1'b0;
    sent = 0;
    for (int c = 0; c < 2000 && sent < 256; c++) begin
      m_rvalid  = (c % 2 == 0);
      m_rdata   = 32'h5000 + sent;
      s0_rready = !(c >= 100 && c < 105);
      #1;
      chk("long_rready", m_rready, s0_rready);
      if (m_rvalid && s0_rready) begin
        chk("long_rvalid", s0_rvalid, 1'b1);
        chk("long_rdata", s0_rdata, 32'h5000 + sent);
        chk("long_grant_held", grant, 2'b01);
        sent++;
      end
      cyc();
    end
    s0_rready = 1'b1;
    m_rvalid  = 1'b1;
    m_rdata   = 32'hDEAD;
    #1;
    chk("long_released_grant", grant, 2'b00);
    chk("long_released_busy", busy, 1'b0);
    chk("long_extra_rready", m_rready, 1'b0);
    chk("long_extra_rvalid", s0_rvalid, 1'b0);
    m_rvalid = 1'b0;
    cyc();

    // Address phase stalled for 10 cycles by m_arready.
    s0_araddr = 32'h6000; s0_arlen = 8'd1; s0_arvalid = 1'b1;
    cyc();
    for (int c = 0; c < 10; c++) begin
      chk("stall_arvalid", m_arvalid, 1'b1);
      chk("stall_araddr", m_araddr, 32'h6000);
      chk("stall_arlen", m_arlen, 8'd1);
      chk("stall_arready", s0_arready, 1'b0);
      cyc();
    end
    serve(0, 32'h6000, 8'd1, 32'h60, 1'b0);

    // Reset pulsed during beat 2 of a 4-beat burst.
    s0_araddr = 32'h6100; s0_arlen = 8'd3; s0_arvalid = 1'b1;
    cyc();
    m_arready = 1'b1;
    cyc();
    m_arready = 1'b0; s0_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h70;
    cyc();
    m_rdata = 32'h71;
    reset_n = 1'b0;
    cyc();
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rready", m_rready, 1'b0);
    chk("midrst_rvalid", s0_rvalid, 1'b0);
    reset_n = 1'b1;
    m_rvalid = 1'b0;
    s1_araddr = 32'h7000; s1_arlen = 8'd2; s1_arvalid = 1'b1;
    cyc();
    serve(1, 32'h7000, 8'd2, 32'h80, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
